// File: rtl/serdes_pkg.sv
// Shared SerDes definitions: FSM state encoding, default word width and the
// even-parity helper used by both the serializer and the deserializer.
package serdes_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int PARITY_MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   // Callers zero-extend narrower words; extra zeros do not change the XOR.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/serializer_hold_buf.sv
// One-entry holding register in front of the serializer shift stage.
// Ready depends only on the full flag; i_drain empties it when the FSM reloads.
module serializer_hold_buf
   import serdes_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_drain,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full
);

   logic [DATA_W-1:0] r_hold;
   logic              r_full;
   logic              w_accept;

   assign w_accept = i_valid & ~r_full;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
         r_full <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold <= i_data;
         end
         // A drain and an accept on the same edge leave the buffer full.
         r_full <= w_accept | (r_full & ~i_drain);
      end
   end

   assign o_ready = ~r_full;
   assign o_data  = r_hold;
   assign o_full  = r_full;

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter with a one-word holding buffer for gapless
// streaming. Define SERIALIZER_PARITY_EN to append an even-parity bit per word.
module serializer
   import serdes_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              data_out,
   output logic              frame_start,
   output logic              busy
);

   localparam int                CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic              r_data_out;
   logic              r_frame_start;
   logic              r_busy;
`ifdef SERIALIZER_PARITY_EN
   logic              r_parity;
`endif

   logic [DATA_W-1:0] w_hold_data;
   logic              w_hold_full;
   logic              w_drain;
   logic              w_last_bit;
   logic              w_first_bit;
   logic              w_next_bit;
   logic [DATA_W-1:0] w_shift_nxt;

   serializer_hold_buf #(
      .DATA_W (DATA_W)
   ) u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .i_data  (data_in),
      .i_valid (load_valid),
      .o_ready (load_ready),
      .i_drain (w_drain),
      .o_data  (w_hold_data),
      .o_full  (w_hold_full)
   );

   assign w_last_bit = (r_state == SHIFT) && (r_bit_cnt == LAST_BIT);

   // Draining the buffer and loading the shift register are the same event.
`ifdef SERIALIZER_PARITY_EN
   assign w_drain = w_hold_full && ((r_state == IDLE) || (r_state == PARITY));
`else
   assign w_drain = w_hold_full && ((r_state == IDLE) || w_last_bit);
`endif

   always_comb begin
      w_first_bit = 1'b0;
      w_next_bit  = 1'b0;
      w_shift_nxt = '0;
      if (MSB_FIRST) begin
         w_first_bit = w_hold_data[DATA_W-1];
         w_next_bit  = r_shift[DATA_W-2];
         w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
      end else begin
         w_first_bit = w_hold_data[0];
         w_next_bit  = r_shift[1];
         w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_data_out    <= 1'b0;
         r_frame_start <= 1'b0;
         r_busy        <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         r_parity      <= 1'b0;
`endif
      end else begin
         r_frame_start <= 1'b0;
         if (w_drain) begin
            // The first bit goes out on the loading edge itself.
            r_state       <= SHIFT;
            r_shift       <= w_hold_data;
            r_bit_cnt     <= '0;
            r_data_out    <= w_first_bit;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            r_parity      <= even_parity(PARITY_MAX_W'(w_hold_data));
`endif
         end else begin
            case (r_state)
               SHIFT: begin
                  if (!w_last_bit) begin
                     r_data_out <= w_next_bit;
                     r_shift    <= w_shift_nxt;
                     r_bit_cnt  <= r_bit_cnt + 1'b1;
                  end else begin
`ifdef SERIALIZER_PARITY_EN
                     r_state    <= PARITY;
                     r_data_out <= r_parity;
`else
                     r_state    <= IDLE;
                     r_data_out <= 1'b0;
                     r_busy     <= 1'b0;
                     r_bit_cnt  <= '0;
`endif
                  end
               end
               default: begin
                  r_state    <= IDLE;
                  r_data_out <= 1'b0;
                  r_busy     <= 1'b0;
                  r_bit_cnt  <= '0;
               end
            endcase
         end
      end
   end

   assign data_out    = r_data_out;
   assign frame_start = r_frame_start;
   assign busy        = r_busy;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: MSB-first and LSB-first instances, checked against a
// frame model built from each word with plain bit arithmetic.
module tb_serializer;

   localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic         clk;
   logic         rst;
   logic [W-1:0] data_in;
   logic         load_valid;
   logic         load_ready;
   logic         data_out;
   logic         frame_start;
   logic         busy;

   logic [W-1:0] l_data_in;
   logic         l_load_valid;
   logic         l_load_ready;
   logic         l_data_out;
   logic         l_frame_start;
   logic         l_busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic exp_q[$];
   int   acc_q[$];
   bit   blk_q[$];
   int   first_cyc;

   serializer #(.DATA_W(W), .MSB_FIRST(1'b1)) u_msb (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .data_out    (data_out),
      .frame_start (frame_start),
      .busy        (busy)
   );

   serializer #(.DATA_W(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk         (clk),
      .rst         (rst),
      .data_in     (l_data_in),
      .load_valid  (l_load_valid),
      .load_ready  (l_load_ready),
      .data_out    (l_data_out),
      .frame_start (l_frame_start),
      .busy        (l_busy)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // Bit i of a word's frame on the wire: data bits in send order, then parity.
   function automatic logic model_bit(input logic [W-1:0] w, input int i, input bit msb);
      if (i < W) return msb ? w[W-1-i] : w[i];
      return logic'($countones(w) % 2);
   endfunction

   task automatic build_expected(input logic [W-1:0] words[$], input bit msb);
      exp_q.delete();
      foreach (words[k])
         for (int i = 0; i < FRAME; i++) exp_q.push_back(model_bit(words[k], i, msb));
   endtask

   // ---------------- driver ----------------
   // Presents a word and holds it until a handshake edge; returns that cycle.
   task automatic push(input logic [W-1:0] w, output int acc, output bit blocked);
      int t = 0;
      data_in    = w;
      load_valid = 1'b1;
      @(negedge clk);
      blocked = !load_ready;
      while (!load_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!load_ready) begin
         checks++; errors++;
         $display("FAIL push_timeout: word %0h load_ready stayed %0b, required 1", w, load_ready);
         load_valid = 1'b0;
         acc = -1;
      end else begin
         @(posedge clk);
         #1;
         acc        = cyc;
         load_valid = 1'b0;
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if ({data_out, frame_start, busy} !== 3'b000) begin
         errors++;
         $display("FAIL %s: {data_out,frame_start,busy}=%b, required 000", name, {data_out, frame_start, busy});
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; load_valid = 1'b0; data_in = '0;
      l_load_valid = 1'b0; l_data_in = '0;
      #1;
      check_idle("reset_outputs");
      checks++;
      if ({load_ready, l_load_ready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_load_ready: got %b, required 11", {load_ready, l_load_ready});
      end
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("post_reset_idle");
   endtask

   task automatic test_single(input logic [W-1:0] w);
      logic [W-1:0] words[$];
      int acc; bit blk;
      words.push_back(w);
      build_expected(words, 1'b1);
      push(w, acc, blk);
      for (int i = 0; i < FRAME; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({data_out, frame_start, busy} !== {exp_q[i], (i == 0), 1'b1}) begin
            errors++;
            $display("FAIL single_%0h_bit%0d: {data_out,frame_start,busy}=%b, required %b",
                     w, i, {data_out, frame_start, busy}, {exp_q[i], (i == 0), 1'b1});
         end
      end
      @(posedge clk); #1;
      check_idle("single_end_idle");
   endtask

   task automatic test_lsb(input logic [W-1:0] w);
      logic [W-1:0] words[$];
      words.push_back(w);
      build_expected(words, 1'b0);
      @(negedge clk);
      l_data_in = w; l_load_valid = 1'b1;
      checks++;
      if (l_load_ready !== 1'b1) begin
         errors++;
         $display("FAIL lsb_ready: got %b, required 1", l_load_ready);
      end
      @(posedge clk); #1;
      l_load_valid = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({l_data_out, l_frame_start, l_busy} !== {exp_q[i], (i == 0), 1'b1}) begin
            errors++;
            $display("FAIL lsb_%0h_bit%0d: {data_out,frame_start,busy}=%b, required %b",
                     w, i, {l_data_out, l_frame_start, l_busy}, {exp_q[i], (i == 0), 1'b1});
         end
      end
      @(posedge clk); #1;
      checks++;
      if ({l_data_out, l_frame_start, l_busy} !== 3'b000) begin
         errors++;
         $display("FAIL lsb_end_idle: got %b, required 000", {l_data_out, l_frame_start, l_busy});
      end
   endtask

   // Pushes words as fast as the DUT accepts them; the line must stay busy.
   task automatic test_back_to_back(input string name, input logic [W-1:0] words[$]);
      build_expected(words, 1'b1);
      acc_q.delete(); blk_q.delete();
      first_cyc = -1;
      fork
         begin
            foreach (words[k]) begin
               int a; bit b;
               push(words[k], a, b);
               acc_q.push_back(a);
               blk_q.push_back(b);
            end
         end
         begin
            int t = 0;
            while (!frame_start && t < 60) begin
               @(posedge clk); #1;
               t++;
            end
            checks++;
            if (!frame_start) begin
               errors++;
               $display("FAIL %s_start_timeout: frame_start=%b, required 1", name, frame_start);
            end else begin
               first_cyc = cyc;
               for (int i = 0; i < exp_q.size(); i++) begin
                  if (i > 0) begin @(posedge clk); #1; end
                  checks++;
                  if ({data_out, frame_start, busy} !== {exp_q[i], (i % FRAME == 0), 1'b1}) begin
                     errors++;
                     $display("FAIL %s_bit%0d: {data_out,frame_start,busy}=%b, required %b",
                              name, i, {data_out, frame_start, busy}, {exp_q[i], (i % FRAME == 0), 1'b1});
                  end
               end
               @(posedge clk); #1;
               check_idle("stream_end_idle");
            end
         end
      join
   endtask

   task automatic test_backpressure();
      logic [W-1:0] words[$];
      words = '{8'hA5, 8'h3C, 8'hFF};
      test_back_to_back("backpressure", words);
      checks++;
      if (blk_q.size() != 3 || blk_q[2] !== 1'b1) begin
         errors++;
         $display("FAIL bp_ff_blocked: blocked flag queue size %0d, required FF to see load_ready=0", blk_q.size());
      end
      checks++;
      if (acc_q.size() != 3 || acc_q[2] < first_cyc + W - 1) begin
         errors++;
         $display("FAIL bp_ff_accept_cycle: accepted at %0d, required >= %0d", 
                  (acc_q.size() == 3) ? acc_q[2] : -1, first_cyc + W - 1);
      end
   endtask

   task automatic test_reset_mid_word();
      fork
         begin
            int a; bit b;
            push(8'hB5, a, b);
            push(8'h3C, a, b);
         end
         begin
            int t = 0;
            while (!frame_start && t < 60) begin
               @(posedge clk); #1;
               t++;
            end
            repeat (3) @(posedge clk);
            #3;
            rst = 1'b1;
            #1;
            check_idle("midword_reset_outputs");
            checks++;
            if (load_ready !== 1'b1) begin
               errors++;
               $display("FAIL midword_reset_ready: got %b, required 1", load_ready);
            end
         end
      join
      data_in = 8'hFF; load_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({load_ready, busy} !== 2'b10) begin
         errors++;
         $display("FAIL valid_during_reset: {load_ready,busy}=%b, required 10", {load_ready, busy});
      end
      @(negedge clk); load_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("held_word_discarded");
      test_single(8'h0F);
   endtask

`ifdef SERIALIZER_PARITY_EN
   task automatic test_parity(input logic [W-1:0] w, input logic par);
      int acc; bit blk;
      push(w, acc, blk);
      repeat (FRAME) @(posedge clk);
      #1;
      checks++;
      if ({data_out, busy} !== {par, 1'b1}) begin
         errors++;
         $display("FAIL parity_%0h: {data_out,busy}=%b, required %b", w, {data_out, busy}, {par, 1'b1});
      end
      @(posedge clk); #1;
      check_idle("parity_end_idle");
   endtask
`endif

   // ---------------- sequence / report ----------------
   initial begin
      logic [W-1:0] words[$];
      test_reset();
      test_single(8'hB5);
      for (int r = 0; r < 3; r++) test_single(W'($urandom_range(0, 255)));
      test_lsb(8'hB5);
      test_lsb(W'($urandom_range(0, 255)));
      words = '{8'hA5, 8'h3C};
      test_back_to_back("b2b", words);
      words.delete();
      for (int r = 0; r < 6; r++) words.push_back(W'($urandom));
      test_back_to_back("rand_stream", words);
      test_backpressure();
      test_reset_mid_word();
`ifdef SERIALIZER_PARITY_EN
      test_parity(8'hB5, 1'b1);
      test_parity(8'h3C, 1'b0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial transmitter. It is the transmit-side counterpart of the team's serial deserializer.
- Accepts a DATA_W-bit word through a valid/ready handshake and shifts it out one bit per clock on a single-bit line.
- Has a one-word holding buffer, so consecutive words stream with no idle gap.
- Sits at the TX end of the SerDes link, directly feeding the deserializer's data_in.

Parameters:
- DATA_W, 8, word width in bits (>=2).
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  parallel word to transmit.
- load_valid  input  1  data_in is valid this cycle.
- load_ready  output  1  holding register is empty; a word is accepted when load_valid and load_ready are both high on a rising edge.
- data_out  output  1  serial bit, registered.
- frame_start  output  1  high during the cycle data_out carries the first bit of a word.
- busy  output  1  a word is currently being shifted (state != IDLE).

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, named rst.
- Reset values: data_out=0, frame_start=0, busy=0, load_ready=1 (holding empty), shift register=0, bit counter=0, state=IDLE.
- Storage:
  - hold_reg (DATA_W) plus hold_full flag.
  - shift_reg (DATA_W).
  - bit_cnt, width $clog2(DATA_W).
- load_ready = ~hold_full. It is combinational from the flag only, never from load_valid.
- Acceptance: on a handshake edge, data_in is written to hold_reg and hold_full is set.
- FSM states: IDLE, SHIFT (plus PARITY when the optional feature is enabled).
- IDLE:
  - If hold_full is set, move hold_reg into shift_reg, clear hold_full, and go to SHIFT.
  - The first bit appears on data_out on that same edge, with frame_start=1.
  - Latency: word accepted at edge N, first bit at edge N+1, last bit at edge N+DATA_W.
- SHIFT:
  - Each edge outputs the next bit and increments bit_cnt.
  - After the bit with bit_cnt=DATA_W-1:
    - If hold_full is set, reload immediately and output the new word's first bit on the next edge with frame_start=1. There is no gap cycle.
    - Otherwise return to IDLE and drive data_out=0.
- Simultaneous events:
  - The holding register is drained and accepts a new word in the same cycle.
  - hold_full therefore stays 1 and the new data is captured. There is no loss and no duplicate.
- Backpressure: with a word shifting and hold_full set, load_ready=0. load_valid is ignored until the holding register drains.
- frame_start: exactly one cycle per word, coincident with the first bit.
- data_out when idle: 0.
- Reset mid-word: asynchronous. All outputs go to their reset values immediately, and both the partial word and the held word are discarded. The first handshake after reset release starts a fresh frame.
- load_valid while rst is high: ignored.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After the last data bit, the FSM enters PARITY for one cycle and outputs the even-parity bit, i.e. the XOR of all data bits.
  - A frame is DATA_W+1 cycles.
  - Back-to-back reload happens after the parity cycle.
  - busy stays high through PARITY.
- Undefined: no PARITY state; a frame is DATA_W cycles.

Decomposition:
- Shared package serdes_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the DATA_W default constant;
  - a parity function reused by the deserializer.
- One natural sub-module, serializer_hold_buf: the one-entry valid/ready holding register (hold_reg, hold_full, load_ready, drain strobe).
- The FSM and shift register stay in the top level.

Test Plan:
- Single word:
  - Stimulus: after reset, hold load_valid with data_in=8'hB5 for one accepted cycle.
  - Response: data_out = 1,0,1,1,0,1,0,1 on edges N+1..N+8; frame_start high only at N+1; busy high for 8 cycles; then data_out=0 and busy=0.
- LSB first:
  - Stimulus: MSB_FIRST=0, data_in=8'hB5.
  - Response: data_out = 1,0,1,0,1,1,0,1.
- Back-to-back:
  - Stimulus: accept 8'hA5 then 8'h3C on consecutive cycles.
  - Response: 16 contiguous bits 10100101_00111100 with no idle cycle; frame_start pulses at bit 1 and at bit 9.
- Backpressure:
  - Stimulus: while 8'hA5 is shifting and 8'h3C is held, present 8'hFF.
  - Response: load_ready=0; 8'hFF is not accepted until A5's last bit; 8'hFF then follows 3C with no gap and no word lost.
- Reset mid-word:
  - Stimulus: assert rst during bit 4 of 8'hB5, between clock edges.
  - Response: data_out, busy and frame_start go to 0 immediately and load_ready goes to 1. A new 8'h0F accepted after release serializes as 0,0,0,0,1,1,1,1.
- Parity (SERIALIZER_PARITY_EN defined):
  - Stimulus: send 8'hB5, which has five 1s.
  - Response: 8 data bits, then parity bit 1 in the 9th cycle with busy still high.
  - Stimulus: send 8'h3C.
  - Response: parity bit 0.
